// File: rtl/ff_bank_pkg.sv
// Shared definitions for the multi-mode flip-flop bank.
// Contents: the flip-flop mode encodings and the mode type.
package ff_bank_pkg;

  typedef logic [1:0] ff_mode_t;

  localparam ff_mode_t MODE_SR = 2'b00;
  localparam ff_mode_t MODE_JK = 2'b01;
  localparam ff_mode_t MODE_D  = 2'b10;
  localparam ff_mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/ff_cell.sv
// One storage channel of the multi-mode flip-flop bank.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - enable for mode-driven update
//   ld, ld_d  - synchronous load and load value (beats en)
//   mode      - SR / JK / D / T selection
//   a, b      - control pair (S/R, J/K, D, T on a)
//   q         - cell state
//   illegal   - combinational: SR mode, ab=11, en=1, ld=0
module ff_cell
  import ff_bank_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     ld,
  input  logic     ld_d,
  input  ff_mode_t mode,
  input  logic     a,
  input  logic     b,
  output logic     q,
  output logic     illegal
);

  logic q_d;

  always_comb begin
    q_d     = q;
    illegal = 1'b0;
    if (ld) begin
      q_d = ld_d;
    end else if (en) begin
      case (mode)
        MODE_SR: begin
          case ({a, b})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   illegal = 1'b1;  // state holds, top logs the event
            default: q_d = q;
          endcase
        end
        MODE_JK: begin
          case ({a, b})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q;
            default: q_d = q;
          endcase
        end
        MODE_D:  q_d = a;
        default: q_d = q ^ a;  // T
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH single-bit cells sharing one run-time-selectable flip-flop mode,
// with parallel load and logging of illegal SR=11 inputs.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - update enable for mode-driven next state
//   mode      - 00=SR, 01=JK, 10=D, 11=T
//   ctl       - per-channel pair, channel i: a=ctl[2i+1], b=ctl[2i]
//   ld        - synchronous parallel load of ld_data
//   clr_err   - synchronous clear of err_vec / err_cnt
//   q, qb     - cell states and their complement
//   err_vec   - sticky per-channel illegal-SR flags
//   err_cnt   - saturating count of cycles with any illegal event
module multi_mode_ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  ff_mode_t           mode,
  input  logic [2*WIDTH-1:0] ctl,
  input  logic               ld,
  input  logic [WIDTH-1:0]   ld_data,
  input  logic               clr_err,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qb,
  output logic [WIDTH-1:0]   err_vec,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] err_vec_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] cnt_base;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .ld     (ld),
      .ld_d   (ld_data[i]),
      .mode   (mode),
      .a      (ctl[2*i+1]),
      .b      (ctl[2*i]),
      .q      (q[i]),
      .illegal(illegal[i])
    );
  end

  assign qb = ~q;

  // Clear is applied before the current cycle's event is logged.
  always_comb begin
    cnt_base  = clr_err ? '0 : err_cnt;
    err_vec_d = (clr_err ? '0 : err_vec) | illegal;
    err_cnt_d = cnt_base;
    if ((|illegal) && (cnt_base != CntMax)) begin
      err_cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_vec <= '0;
      err_cnt <= '0;
    end else begin
      err_vec <= err_vec_d;
      err_cnt <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed, table-driven bench for multi_mode_ff_bank (WIDTH=8, CNT_W=2).
module tb_multi_mode_ff_bank;

  localparam int W = 8;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [1:0]     mode;
  logic [2*W-1:0] ctl;
  logic           ld;
  logic [W-1:0]   ld_data;
  logic           clr_err;
  logic [W-1:0]   q, qb, err_vec;
  logic [C-1:0]   err_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  multi_mode_ff_bank #(.WIDTH(W), .CNT_W(C)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .ctl    (ctl),
    .ld     (ld),
    .ld_data(ld_data),
    .clr_err(clr_err),
    .q      (q),
    .qb     (qb),
    .err_vec(err_vec),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic           ld;
    logic [W-1:0]   ld_data;
    logic           en;
    logic [1:0]     mode;
    logic [2*W-1:0] ctl;
    logic           clr_err;
    logic [W-1:0]   exp_q;
    logic [W-1:0]   exp_ev;
    logic [C-1:0]   exp_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string name, input logic l, input logic [W-1:0] ldd, input logic e,
                     input logic [1:0] m, input logic [2*W-1:0] c, input logic clr,
                     input logic [W-1:0] eq, input logic [W-1:0] eev, input logic [C-1:0] ec);
    vec_t v;
    v.name = name; v.ld = l; v.ld_data = ldd; v.en = e; v.mode = m; v.ctl = c;
    v.clr_err = clr; v.exp_q = eq; v.exp_ev = eev; v.exp_cnt = ec;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] eq, input logic [W-1:0] eev,
                       input logic [C-1:0] ec);
    logic [W-1:0] eqb;
    eqb = ~eq;
    n_vec++;
    if (q !== eq) begin
      n_miss++;
      $display("FAIL %s q: got %h want %h", name, q, eq);
    end
    if (qb !== eqb) begin
      n_miss++;
      $display("FAIL %s qb: got %h want %h", name, qb, eqb);
    end
    if (err_vec !== eev) begin
      n_miss++;
      $display("FAIL %s err_vec: got %h want %h", name, err_vec, eev);
    end
    if (err_cnt !== ec) begin
      n_miss++;
      $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, ec);
    end
  endtask

  task automatic drive(input logic l, input logic [W-1:0] ldd, input logic e, input logic [1:0] m,
                       input logic [2*W-1:0] c, input logic clr);
    @(negedge clk);
    ld = l; ld_data = ldd; en = e; mode = m; ctl = c; clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; ctl = '0; ld = 1'b0; ld_data = '0; clr_err = 1'b0;

    // name ld ld_data en mode ctl clr | q ev cnt
    add("sr_set0",    0, 8'h00, 1, 2'b00, 16'h0002, 0, 8'h01, 8'h00, 2'd0);
    add("sr_hold0",   0, 8'h00, 1, 2'b00, 16'h0000, 0, 8'h01, 8'h00, 2'd0);
    add("sr_rst0",    0, 8'h00, 1, 2'b00, 16'h0001, 0, 8'h00, 8'h00, 2'd0);
    add("sr_set0b",   0, 8'h00, 1, 2'b00, 16'h0002, 0, 8'h01, 8'h00, 2'd0);
    add("sr_ill0",    0, 8'h00, 1, 2'b00, 16'h0003, 0, 8'h01, 8'h01, 2'd1);
    add("ld_0f",      1, 8'h0F, 0, 2'b00, 16'hFFFF, 0, 8'h0F, 8'h01, 2'd1);
    add("jk_tog1",    0, 8'h00, 1, 2'b01, 16'hFFFF, 0, 8'hF0, 8'h01, 2'd1);
    add("jk_tog2",    0, 8'h00, 1, 2'b01, 16'hFFFF, 0, 8'h0F, 8'h01, 2'd1);
    add("jk_tog3",    0, 8'h00, 1, 2'b01, 16'hFFFF, 0, 8'hF0, 8'h01, 2'd1);
    add("en_off",     0, 8'h00, 0, 2'b00, 16'hFFFF, 0, 8'hF0, 8'h01, 2'd1);
    add("t_ch7_1",    0, 8'h00, 1, 2'b11, 16'h8000, 0, 8'h70, 8'h01, 2'd1);
    add("t_ch7_2",    0, 8'h00, 1, 2'b11, 16'h8000, 0, 8'hF0, 8'h01, 2'd1);
    add("t_ch7_3",    0, 8'h00, 1, 2'b11, 16'h8000, 0, 8'h70, 8'h01, 2'd1);
    add("clr_only",   0, 8'h00, 0, 2'b00, 16'h0000, 1, 8'h70, 8'h00, 2'd0);
    add("ld_prio",    1, 8'h3C, 1, 2'b00, 16'hFFFF, 0, 8'h3C, 8'h00, 2'd0);
    add("d_cmpl",     0, 8'h00, 1, 2'b10, 16'hA01A, 0, 8'hC3, 8'h00, 2'd0);
    add("sat1",       0, 8'h00, 1, 2'b00, 16'h003C, 0, 8'hC3, 8'h06, 2'd1);
    add("sat2",       0, 8'h00, 1, 2'b00, 16'h003C, 0, 8'hC3, 8'h06, 2'd2);
    add("sat3",       0, 8'h00, 1, 2'b00, 16'h003C, 0, 8'hC3, 8'h06, 2'd3);
    add("sat4",       0, 8'h00, 1, 2'b00, 16'h003C, 0, 8'hC3, 8'h06, 2'd3);
    add("sat5",       0, 8'h00, 1, 2'b00, 16'h003C, 0, 8'hC3, 8'h06, 2'd3);
    add("clr_coll",   0, 8'h00, 1, 2'b00, 16'h0300, 1, 8'hC3, 8'h10, 2'd1);
    add("clr_after",  0, 8'h00, 0, 2'b00, 16'h0000, 1, 8'hC3, 8'h00, 2'd0);
    add("sr_mixed",   0, 8'h00, 1, 2'b00, 16'h4020, 0, 8'h47, 8'h00, 2'd0);
    add("mode_swap",  0, 8'h00, 1, 2'b10, 16'h0000, 0, 8'h00, 8'h00, 2'd0);

    // Reset release away from the edge, then check reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", 8'h00, 8'h00, 2'd0);

    foreach (vq[i]) begin
      drive(vq[i].ld, vq[i].ld_data, vq[i].en, vq[i].mode, vq[i].ctl, vq[i].clr_err);
      check(vq[i].name, vq[i].exp_q, vq[i].exp_ev, vq[i].exp_cnt);
    end

    // Build q=A5, err_cnt=3, then assert reset mid-cycle.
    drive(1, 8'hA5, 0, 2'b00, 16'h0000, 0);
    check("pre_a5", 8'hA5, 8'h00, 2'd0);
    repeat (3) drive(0, 8'h00, 1, 2'b00, 16'h0003, 0);
    check("pre_cnt3", 8'hA5, 8'h01, 2'd3);
    #2;
    ld = 1'b1; ld_data = 8'hFF; en = 1'b0; ctl = '0;
    rst = 1'b1;
    #1;
    check("async_rst", 8'h00, 8'h00, 2'd0);
    @(posedge clk);
    #1;
    check("rst_beats_ld", 8'h00, 8'h00, 2'd0);
    @(negedge clk);
    ld = 1'b0;
    rst = 1'b0;
    drive(0, 8'h00, 1, 2'b10, 16'h8000, 0);
    check("post_rst_d", 8'h80, 8'h00, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
